// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream valid/ready/data,
// downstream valid/ready/data, flush and the stage occupancy.
interface pipe_stage_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush to a bubble
// pattern and an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_skid_reg #(
  parameter int             WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter bit             SKID      = 1'b1
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic             accept;
  logic             pop;

  // With the skid buffer in_ready depends only on state flops; without it the
  // stage can refill in the same cycle it drains.
  assign bus.in_ready  = SKID ? (state_q != TWO) : ((state_q == EMPTY) || bus.out_ready);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
    end
  end

  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (bus.flush) begin
      state_n = EMPTY;
      main_n  = FLUSH_VAL;
      skid_n  = FLUSH_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            main_n  = bus.in_data;
          end
        end
        ONE: begin
          // Without the skid buffer, accept in ONE always coincides with a pop.
          if (accept && pop) begin
            main_n = bus.in_data;
          end else if (accept) begin
            if (SKID) begin
              state_n = TWO;
              skid_n  = bus.in_data;
            end
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_n = ONE;
            main_n  = skid_q;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.occupancy = 2'd0;
    case (state_q)
      ONE:     bus.occupancy = 2'd1;
      TWO:     bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench: a FIFO model of at most two entries predicts in_ready, occupancy
// and the delivered payload order; a SKID=0 instance gets directed handshake checks.
module tb_pipe_stage_skid_reg;

  localparam int          WIDTH = 32;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_stage_skid_reg_if #(.WIDTH(WIDTH)) sb ();
  pipe_stage_skid_reg_if #(.WIDTH(WIDTH)) nb ();

  pipe_stage_skid_reg #(.WIDTH(WIDTH), .FLUSH_VAL(BUBBLE), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .bus(sb)
  );

  pipe_stage_skid_reg #(.WIDTH(WIDTH), .FLUSH_VAL(BUBBLE), .SKID(1'b0)) u_noskid (
    .clk(clk), .rst(rst), .bus(nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus on the skid instance; the model decides acceptance from
  // its own depth and updates at the edge (flush discards whatever is still held).
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic ordy, input logic fl);
    logic acc;
    @(negedge clk);
    sb.in_valid  = v;
    sb.in_data   = d;
    sb.out_ready = ordy;
    sb.flush     = fl;
    acc = v && (exp_q.size() < 2);
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
  endtask

  // Monitor: samples between edges, compares against the model and retires delivered entries.
  always begin
    @(negedge clk);
    #1;
    check("occupancy", {62'd0, sb.occupancy}, 64'(exp_q.size()));
    check("in_ready", {63'd0, sb.in_ready}, {63'd0, exp_q.size() < 2});
    check("out_valid", {63'd0, sb.out_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("out_data", {32'd0, sb.out_data}, {32'd0, exp_q[0]});
      if (sb.out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic checkOutput(string name, logic ov, logic [WIDTH-1:0] od, logic [1:0] occ);
    check({name, ".out_valid"}, {63'd0, sb.out_valid}, {63'd0, ov});
    check({name, ".out_data"}, {32'd0, sb.out_data}, {32'd0, od});
    check({name, ".occupancy"}, {62'd0, sb.occupancy}, {62'd0, occ});
  endtask

  initial begin
    rst = 1'b1;
    sb.in_valid = 1'b0; sb.in_data = '0; sb.out_ready = 1'b0; sb.flush = 1'b0;
    nb.in_valid = 1'b0; nb.in_data = '0; nb.out_ready = 1'b0; nb.flush = 1'b0;
    #3;
    checkOutput("reset", 1'b0, BUBBLE, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.in_ready", {63'd0, sb.in_ready}, 64'd1);

    // Streaming at full rate
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0); #2; checkOutput("stream0", 1'b1, 32'h11, 2'd1);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0); #2; checkOutput("stream1", 1'b1, 32'h22, 2'd1);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0); #2; checkOutput("stream2", 1'b1, 32'h33, 2'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);  #2; check("stream.drain", {62'd0, sb.occupancy}, 64'd0);

    // Stall fills the skid entry, then drains in order
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0); #2;
    checkOutput("skid.full", 1'b1, 32'hA1, 2'd2);
    check("skid.in_ready", {63'd0, sb.in_ready}, 64'd0);
    applyStimulus(1'b1, 32'hEE, 1'b0, 1'b0); #2; checkOutput("skid.hold", 1'b1, 32'hA1, 2'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);  #2; checkOutput("skid.pop1", 1'b1, 32'hA2, 2'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);  #2; check("skid.pop2", {62'd0, sb.occupancy}, 64'd0);

    // Flush while full, with an offered payload that must never surface
    applyStimulus(1'b1, 32'hA3, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA4, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBB, 1'b0, 1'b1); #2; checkOutput("flush.full", 1'b0, BUBBLE, 2'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);  #2; checkOutput("flush.after", 1'b0, BUBBLE, 2'd0);
    // Flush from ONE: the pop is delivered, the accepted payload is dropped
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b1, 1'b1); #2; checkOutput("flush.one", 1'b0, BUBBLE, 2'd0);
    // Payload equal to the bubble pattern is still a real entry
    applyStimulus(1'b1, BUBBLE, 1'b0, 1'b0); #2; checkOutput("bubble.data", 1'b1, BUBBLE, 2'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset mid-operation
    applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hD2, 1'b0, 1'b0);
    #2;
    sb.in_valid = 1'b0; sb.out_ready = 1'b0; sb.flush = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("midreset", 1'b0, BUBBLE, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midreset.in_ready", {63'd0, sb.in_ready}, 64'd1);

    // SKID=0: combinational ready follows out_ready, one transfer per cycle
    @(negedge clk);
    nb.in_valid = 1'b1; nb.in_data = 32'h55; nb.out_ready = 1'b0;
    #1; check("noskid.empty_ready", {63'd0, nb.in_ready}, 64'd1);
    @(negedge clk);
    nb.in_valid = 1'b0;
    #1; check("noskid.stall_ready", {63'd0, nb.in_ready}, 64'd0);
    check("noskid.hold_data", {32'd0, nb.out_data}, 64'h55);
    nb.out_ready = 1'b1; nb.in_valid = 1'b1; nb.in_data = 32'h66;
    #1; check("noskid.release_ready", {63'd0, nb.in_ready}, 64'd1);
    @(negedge clk);
    #1; check("noskid.data66", {32'd0, nb.out_data}, 64'h66);
    check("noskid.occ", {62'd0, nb.occupancy}, 64'd1);
    nb.in_data = 32'h77;
    @(negedge clk);
    #1; check("noskid.data77", {32'd0, nb.out_data}, 64'h77);
    nb.in_valid = 1'b0;
    @(negedge clk);
    #1; check("noskid.drained", {63'd0, nb.out_valid}, 64'd0);
    check("noskid.occ0", {62'd0, nb.occupancy}, 64'd0);
    nb.out_ready = 1'b0;

    // Randomised traffic with phases of heavy and light back-pressure
    for (int i = 0; i < 10000; i++) begin
      int rbias;
      rbias = ((i / 64) % 2 == 0) ? 3 : 1;
      applyStimulus($urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 3) < rbias, $urandom_range(0, 49) == 0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    check("final.empty", {62'd0, sb.occupancy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
